// File: rtl/lane_gate_arbiter.sv
// Shared gate-lane arbiter: latches entry/exit requests, grants one direction at a time,
// closes on car pass or timeout. Optional served-car counters under LANE_STATS_EN.
module lane_gate_arbiter #(
  parameter int CAPACITY     = 16,
  parameter int CNT_W        = 5,
  parameter int OPEN_CYCLES  = 100_000_000,
  parameter int CLOSE_CYCLES = 25_000_000,
  parameter int TMR_W        = 27
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             entry_req,
  input  logic             exit_req,
  input  logic [CNT_W-1:0] count,
  input  logic             car_entered,
  input  logic             car_exited,
  output logic             gate_open,
  output logic             grant_entry,
  output logic             grant_exit,
  output logic             full,
  output logic             deny,
  output logic             timeout,
  output logic [15:0]      n_entries,
  output logic [15:0]      n_exits
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_OPEN_IN  = 2'd1,
    S_OPEN_OUT = 2'd2,
    S_CLOSING  = 2'd3
  } state_t;

  localparam logic [CNT_W:0]   CAP_V      = (CNT_W+1)'(CAPACITY);
  localparam logic [TMR_W-1:0] OPEN_LAST  = TMR_W'(OPEN_CYCLES - 1);
  localparam logic [TMR_W-1:0] CLOSE_LAST = TMR_W'(CLOSE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [TMR_W-1:0] r_tmr;
  logic [TMR_W-1:0] w_tmr_nxt;
  logic             r_pend_in;
  logic             r_pend_out;
  logic             r_last_out;
  logic             w_pend_in_nxt;
  logic             w_pend_out_nxt;
  logic             w_last_out_nxt;
  logic             w_at_cap;
  logic             w_in_ok;
  logic             w_drop;
  logic             w_grant_in;
  logic             w_grant_out;
  logic             w_timeout;
  logic             w_deny;

  logic r_gate_open;
  logic r_grant_entry;
  logic r_grant_exit;
  logic r_full;
  logic r_deny;
  logic r_timeout;

  assign w_at_cap = ({1'b0, count} >= CAP_V);

  // Next-state, arbitration and pending-flag update
  always_comb begin
    w_state_nxt    = r_state;
    w_last_out_nxt = r_last_out;
    w_in_ok        = 1'b0;
    w_drop         = 1'b0;
    w_grant_in     = 1'b0;
    w_grant_out    = 1'b0;
    w_timeout      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_drop  = r_pend_in & w_at_cap;
        w_in_ok = r_pend_in & ~w_at_cap;
        if (w_in_ok && (!r_pend_out || r_last_out)) begin
          w_grant_in     = 1'b1;
          w_state_nxt    = S_OPEN_IN;
          w_last_out_nxt = 1'b0;
        end else if (r_pend_out) begin
          w_grant_out    = 1'b1;
          w_state_nxt    = S_OPEN_OUT;
          w_last_out_nxt = 1'b1;
        end else begin
          w_state_nxt    = S_IDLE;
        end
      end
      S_OPEN_IN: begin
        if (car_entered) begin
          w_state_nxt = S_CLOSING;
        end else if (r_tmr == OPEN_LAST) begin
          w_state_nxt = S_CLOSING;
          w_timeout   = 1'b1;
        end else begin
          w_state_nxt = S_OPEN_IN;
        end
      end
      S_OPEN_OUT: begin
        if (car_exited) begin
          w_state_nxt = S_CLOSING;
        end else if (r_tmr == OPEN_LAST) begin
          w_state_nxt = S_CLOSING;
          w_timeout   = 1'b1;
        end else begin
          w_state_nxt = S_OPEN_OUT;
        end
      end
      S_CLOSING: begin
        if (r_tmr == CLOSE_LAST) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_CLOSING;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // A request arriving on the grant cycle merges into the flag being cleared
    w_pend_in_nxt  = r_pend_in | (entry_req & ~w_at_cap);
    w_pend_out_nxt = r_pend_out | exit_req;
    if (w_grant_in || w_drop) begin
      w_pend_in_nxt = 1'b0;
    end else begin
      w_pend_in_nxt = w_pend_in_nxt;
    end
    if (w_grant_out) begin
      w_pend_out_nxt = 1'b0;
    end else begin
      w_pend_out_nxt = w_pend_out_nxt;
    end

    w_deny = (entry_req & w_at_cap) | w_drop;

    if (w_state_nxt != r_state) begin
      w_tmr_nxt = '0;
    end else if (r_state == S_IDLE) begin
      w_tmr_nxt = '0;
    end else begin
      w_tmr_nxt = r_tmr + TMR_ONE;
    end
  end

  // State, timer, flags and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_tmr         <= '0;
      r_pend_in     <= 1'b0;
      r_pend_out    <= 1'b0;
      r_last_out    <= 1'b0;
      r_gate_open   <= 1'b0;
      r_grant_entry <= 1'b0;
      r_grant_exit  <= 1'b0;
      r_full        <= 1'b0;
      r_deny        <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_tmr         <= w_tmr_nxt;
      r_pend_in     <= w_pend_in_nxt;
      r_pend_out    <= w_pend_out_nxt;
      r_last_out    <= w_last_out_nxt;
      r_gate_open   <= (w_state_nxt == S_OPEN_IN) | (w_state_nxt == S_OPEN_OUT);
      r_grant_entry <= (w_state_nxt == S_OPEN_IN);
      r_grant_exit  <= (w_state_nxt == S_OPEN_OUT);
      r_full        <= w_at_cap;
      r_deny        <= w_deny;
      r_timeout     <= w_timeout;
    end
  end

  assign gate_open   = r_gate_open;
  assign grant_entry = r_grant_entry;
  assign grant_exit  = r_grant_exit;
  assign full        = r_full;
  assign deny        = r_deny;
  assign timeout     = r_timeout;

`ifdef LANE_STATS_EN
  logic [15:0] r_n_entries;
  logic [15:0] r_n_exits;
  logic        w_pass_in;
  logic        w_pass_out;

  assign w_pass_in  = (r_state == S_OPEN_IN) & car_entered;
  assign w_pass_out = (r_state == S_OPEN_OUT) & car_exited;

  // Saturating served-car counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_n_entries <= 16'h0000;
      r_n_exits   <= 16'h0000;
    end else begin
      if (w_pass_in && (r_n_entries != 16'hFFFF)) begin
        r_n_entries <= r_n_entries + 16'h0001;
      end
      if (w_pass_out && (r_n_exits != 16'hFFFF)) begin
        r_n_exits <= r_n_exits + 16'h0001;
      end
    end
  end

  assign n_entries = r_n_entries;
  assign n_exits   = r_n_exits;
`else
  assign n_entries = 16'h0000;
  assign n_exits   = 16'h0000;
`endif

endmodule

// File: tb/tb_lane_gate_arbiter.sv
// Scoreboard bench for lane_gate_arbiter: directed scenarios plus random traffic
// against a phase/countdown reference model of the lane.
module tb_lane_gate_arbiter;

  localparam int CAP     = 16;
  localparam int CNT_W   = 5;
  localparam int OPEN_C  = 8;
  localparam int CLOSE_C = 2;
  localparam int TMR_W   = 4;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             entry_req = 1'b0;
  logic             exit_req = 1'b0;
  logic [CNT_W-1:0] count = '0;
  logic             car_entered = 1'b0;
  logic             car_exited = 1'b0;
  logic             gate_open, grant_entry, grant_exit, full, deny, timeout;
  logic [15:0]      n_entries, n_exits;

  lane_gate_arbiter #(
    .CAPACITY(CAP), .CNT_W(CNT_W), .OPEN_CYCLES(OPEN_C),
    .CLOSE_CYCLES(CLOSE_C), .TMR_W(TMR_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .entry_req(entry_req), .exit_req(exit_req),
    .count(count), .car_entered(car_entered), .car_exited(car_exited),
    .gate_open(gate_open), .grant_entry(grant_entry), .grant_exit(grant_exit),
    .full(full), .deny(deny), .timeout(timeout),
    .n_entries(n_entries), .n_exits(n_exits)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        gate_open;
    logic        grant_entry;
    logic        grant_exit;
    logic        full;
    logic        deny;
    logic        timeout;
    logic [15:0] n_ent;
    logic [15:0] n_ext;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e, mon_a;
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;

  // Reference model: owner 0=idle, 1=entry open, 2=exit open, 3=settling
  bit m_want_in, m_want_out, m_last_out;
  int m_owner, m_left, m_nent, m_next;
  int n_timeouts = 0, n_denies = 0;

  function automatic void model_reset();
    m_want_in = 0; m_want_out = 0; m_last_out = 0;
    m_owner = 0; m_left = 0; m_nent = 0; m_next = 0;
  endfunction

  function automatic exp_t model_step(bit er, bit xr, int cnt, bit ce, bit cx);
    exp_t e;
    bit full_now, nwi, nwo, dn, to, in_ok, pass;
    full_now = (cnt >= CAP);
    dn = er && full_now;
    to = 0;
    nwi = m_want_in | (er && !full_now);
    nwo = m_want_out | xr;
    case (m_owner)
      0: begin
        if (m_want_in && full_now) begin dn = 1; nwi = 0; end
        in_ok = m_want_in && !full_now;
        if (in_ok && (!m_want_out || m_last_out)) begin
          m_owner = 1; m_left = OPEN_C; nwi = 0; m_last_out = 0;
        end else if (m_want_out) begin
          m_owner = 2; m_left = OPEN_C; nwo = 0; m_last_out = 1;
        end
      end
      1, 2: begin
        pass = (m_owner == 1) ? ce : cx;
        if (pass) begin
          if (m_owner == 1) m_nent = (m_nent < 65535) ? m_nent + 1 : m_nent;
          else              m_next = (m_next < 65535) ? m_next + 1 : m_next;
          m_owner = 3; m_left = CLOSE_C;
        end else if (m_left == 1) begin
          to = 1; m_owner = 3; m_left = CLOSE_C;
        end else begin
          m_left = m_left - 1;
        end
      end
      default: begin
        if (m_left == 1) m_owner = 0;
        else             m_left = m_left - 1;
      end
    endcase
    m_want_in = nwi;
    m_want_out = nwo;
    if (to) n_timeouts++;
    if (dn) n_denies++;
    e.gate_open   = (m_owner == 1) || (m_owner == 2);
    e.grant_entry = (m_owner == 1);
    e.grant_exit  = (m_owner == 2);
    e.full        = full_now;
    e.deny        = dn;
    e.timeout     = to;
`ifdef LANE_STATS_EN
    e.n_ent = m_nent[15:0];
    e.n_ext = m_next[15:0];
`else
    e.n_ent = 16'h0000;
    e.n_ext = 16'h0000;
`endif
    return e;
  endfunction

  task automatic cyc(input bit er, input bit xr, input int cnt, input bit ce, input bit cx);
    @(posedge clk);
    #1;
    entry_req = er; exit_req = xr; count = cnt[CNT_W-1:0];
    car_entered = ce; car_exited = cx;
    exp_q.push_back(model_step(er, xr, cnt, ce, cx));
  endtask

  task automatic idle_cycles(input int n, input int cnt);
    for (int i = 0; i < n; i++) cyc(0, 0, cnt, 0, 0);
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Monitor: one scoreboard comparison per cycle, sampled on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        mon_a = {gate_open, grant_entry, grant_exit, full, deny, timeout, n_entries, n_exits};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL scoreboard_empty t=%0t", $time);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_a !== mon_e) begin
            failures++;
            $display("FAIL cycle_outputs t=%0t got go/ge/gx/full/deny/to=%b%b%b%b%b%b ne=%0d nx=%0d want %b%b%b%b%b%b ne=%0d nx=%0d",
                     $time, mon_a.gate_open, mon_a.grant_entry, mon_a.grant_exit, mon_a.full,
                     mon_a.deny, mon_a.timeout, mon_a.n_ent, mon_a.n_ext,
                     mon_e.gate_open, mon_e.grant_entry, mon_e.grant_exit, mon_e.full,
                     mon_e.deny, mon_e.timeout, mon_e.n_ent, mon_e.n_ext);
          end
        end
      end
    end
  end

  initial begin
    int cnt;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({gate_open, grant_entry, grant_exit, full, deny, timeout, n_entries, n_exits}), 64'h0);
    #1;
    reset_n = 1'b1;
    exp_q.push_back('0);
    mon_en = 1'b1;

    // single entry with pass
    cyc(1, 0, 3, 0, 0); idle_cycles(3, 3); cyc(0, 0, 3, 1, 0); idle_cycles(4, 3);
    // simultaneous after reset-like state: exit first, then entry times out
    cyc(1, 1, 3, 0, 0); idle_cycles(3, 3); cyc(0, 0, 3, 0, 1); idle_cycles(16, 3);
    // exit timeout
    cyc(0, 1, 3, 0, 0); idle_cycles(14, 3);
    // full lot: entry refused, exit still served
    cyc(1, 0, 16, 0, 0); cyc(0, 1, 16, 0, 0); idle_cycles(3, 16);
    cyc(0, 0, 16, 1, 0); cyc(0, 0, 16, 0, 1); idle_cycles(4, 16);
    // becomes full while entry pending during OPEN_OUT
    cyc(0, 1, 5, 0, 0); idle_cycles(2, 5); cyc(1, 0, 5, 0, 0); idle_cycles(2, 5);
    cyc(0, 0, 16, 0, 1); idle_cycles(5, 16); idle_cycles(3, 5);

    // random traffic
    cnt = 3;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) cnt = $urandom_range(0, 20);
      cyc($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, cnt,
          $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
    end

    // async reset mid OPEN_IN with stale requests pending
    idle_cycles(30, 3);
    cyc(1, 0, 3, 0, 0); cyc(0, 0, 3, 0, 0); cyc(1, 1, 3, 0, 0); cyc(0, 0, 3, 0, 0);
    mon_en = 1'b0;
    chk("open_in_before_reset", 64'({gate_open, grant_entry}), 64'(m_owner == 1 ? 2'b11 : 2'b00));
    exp_q.delete();
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_outputs", 64'({gate_open, grant_entry, grant_exit, full, deny, timeout, n_entries, n_exits}), 64'h0);
    model_reset();
    entry_req = 0; exit_req = 0; count = '0; car_entered = 0; car_exited = 0;
    repeat (2) @(negedge clk);
    #1;
    reset_n = 1'b1;
    exp_q.push_back('0);
    mon_en = 1'b1;
    idle_cycles(8, 3);
    cyc(0, 1, 3, 0, 0); idle_cycles(4, 3); cyc(0, 0, 3, 0, 1); idle_cycles(4, 3);
    @(negedge clk);
    #1;
    mon_en = 1'b0;

    $display("info: timeouts=%0d denies=%0d", n_timeouts, n_denies);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lane_gate_arbiter.md
# lane_gate_arbiter

Arbiter and sequencer for a single shared gate lane in the parking-lot design. It latches entrance and exit requests, grants the lane to one direction at a time, holds the gate open until the car-detection FSM reports the car passed or a timeout fires, and then closes the gate. It sits between the request buttons and the gate actuator (GPIO), takes the occupancy count from the car counter, and refuses entry when the lot is full.

## Interface
- CAPACITY, 16, lot size; entry is refused when count ≥ CAPACITY
- CNT_W, 5, width of count input
- OPEN_CYCLES, 100_000_000, maximum gate-open time in clk cycles (≥2)
- CLOSE_CYCLES, 25_000_000, gate-closed settle time before next grant (≥1)
- TMR_W, 27, timer width; must hold max(OPEN_CYCLES, CLOSE_CYCLES)
- clk  in  1  system clock (50 MHz)
- reset_n  in  1  asynchronous, active-low reset
- entry_req  in  1  one-cycle request pulse from entrance
- exit_req  in  1  one-cycle request pulse from exit
- count  in  CNT_W  current occupancy from car counter
- car_entered  in  1  one-cycle pulse, car completed entry
- car_exited  in  1  one-cycle pulse, car completed exit
- gate_open  out  1  gate actuator drive
- grant_entry  out  1  lane granted to entering car
- grant_exit  out  1  lane granted to exiting car
- full  out  1  registered (count ≥ CAPACITY)
- deny  out  1  one-cycle pulse, entry request refused
- timeout  out  1  one-cycle pulse, gate closed by timer
- n_entries, n_exits  out  16  served-car counters (see Configuration)

## Operation
- Pending flags pend_in and pend_out are set by their request pulses and cleared on grant. Repeated requests while a flag is pending merge into it.
- If entry_req arrives while count ≥ CAPACITY, pend_in is not set and deny pulses.
- States:
  - IDLE: gate closed, no grant.
  - OPEN_IN / OPEN_OUT: gate_open=1 and the matching grant=1.
  - CLOSING: gate_open=0, no grant.
- IDLE → OPEN_x when a flag is pending. If both are pending, use round-robin on last_served: the side not served last wins. After reset, last_served = entry, so exit wins the first tie.
- In IDLE, if pend_in is pending but count ≥ CAPACITY: drop pend_in, pulse deny, and take pend_out if it is set.
- OPEN_IN → CLOSING on car_entered. OPEN_OUT → CLOSING on car_exited. The opposite-direction pulse is ignored while open.
- OPEN_x → CLOSING when the timer reaches OPEN_CYCLES−1 without the pass pulse; timeout pulses. If the pass pulse and the timeout coincide, the pass wins and timeout stays low.
- CLOSING lasts exactly CLOSE_CYCLES cycles, then → IDLE.
- Timer: clears on every state entry and increments each cycle in OPEN_x and CLOSING.
- Requests keep latching in every state.
- Reset: state=IDLE, all flags/timer/counters 0, every output 0.

## Timing
- All outputs are registered.
- Request pulse at edge t → pending at t+1 → grant_x/gate_open high at t+2 (if IDLE with nothing competing).
- deny: asserted the cycle after the refused request or the IDLE drop.
- Pass pulse at edge t → gate_open low at t+1.
- A request already pending when CLOSING ends → grant on the cycle after entering IDLE.
- reset_n asserted mid-open → gate_open low immediately (asynchronous).
- full follows count with one cycle of latency.

## Configuration
- LANE_STATS_EN defined:
  - n_entries increments on each car_entered seen in OPEN_IN.
  - n_exits increments on each car_exited seen in OPEN_OUT.
  - Both are 16-bit, saturate at 0xFFFF, and clear on reset.
- LANE_STATS_EN undefined: n_entries and n_exits are tied to 0 and no counter logic is built.

## Test plan
All scenarios use CAPACITY=16, OPEN_CYCLES=8, CLOSE_CYCLES=2.
- Single entry: count=3, entry_req at t → grant_entry=gate_open=1 at t+2; car_entered at t+4 → gate_open=0 at t+5, IDLE at t+7; n_entries=1 with LANE_STATS_EN.
- Simultaneous requests after reset: entry_req and exit_req in the same cycle → grant_exit first; after car_exited and CLOSING, grant_entry with no new request.
- Full lot: count=16, entry_req → deny pulse the next cycle, no grant, gate stays closed; exit_req is still served.
- Timeout: grant_exit with no car_exited → gate_open high for 8 cycles, one timeout pulse, CLOSING for 2 cycles, IDLE; n_exits unchanged.
- Becomes full while pending: entry pending during an OPEN_OUT, count driven to 16 before IDLE → deny pulse in IDLE, pend_in cleared, no grant_entry.
- Async reset mid-OPEN_IN: reset_n low → gate_open, grant_entry and all counters 0 at once; after release, IDLE with no stale pending request.
